vend_ctrl: RTL
==============

# vend_ctrl

Parametrised vending-machine controller; successor to the fixed two-product water/soda FSM. It accepts validated coin strobes, accumulates credit and serves one of N_PROD products priced from a shared table. Delivery and change delays are counted in clock cycles, not simulation delays. It sits between the coin acceptor / keypad front end and the dispenser / change-hopper drivers.

## Interface
- CREDIT_W, 16: credit, coin and change width in cents.
- N_PROD, 4: number of selectable products, 1..8.
- DELIV_CYC, 10: cycles from accepted selection to product delivery, ≥1.
- CHANGE_CYC, 20: cycles from entering change to change pulse, ≥1.
- MAX_CREDIT, 500: credit ceiling; must fit in CREDIT_W.
- SEL_W, $clog2(N_PROD) (minimum 1): derived, not overridable.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- coin_in  in  CREDIT_W  coin value; sampled only when coin_valid.
- coin_valid  in  1  one-cycle coin strobe.
- sel_in  in  SEL_W  product index; sampled only when sel_valid.
- sel_valid  in  1  one-cycle selection strobe.
- cancel_in  in  1  refund request (see Configuration).
- beverage_out  out  N_PROD  one-hot delivery pulse, one cycle.
- change_out  out  CREDIT_W  change amount; valid only with change_valid, else 0.
- change_valid  out  1  one-cycle change pulse.
- coin_reject  out  1  one-cycle pulse, the cycle after a rejected coin strobe.
- credit_out  out  CREDIT_W  current credit.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, DELIV_WAIT, DELIVER, CHANGE_WAIT, CHANGE.
- Reset (async, any state): state IDLE; credit 0; counter 0; all outputs 0.
- IDLE, priority order:
  1. sel_valid with sel_in < N_PROD and credit ≥ PRICE[sel_in]: latch index, go to DELIV_WAIT, load counter.
  2. coin_valid with a legal coin and credit + coin ≤ MAX_CREDIT: add the coin to credit.
  3. Any other coin_valid: pulse coin_reject; credit unchanged.
- An unaffordable or out-of-range selection is ignored; a coin strobed in the same cycle is then processed under rule 2.
- If an accepted selection and a coin strobe arrive together, the coin is rejected.
- Legal coins: 10, 20, 50, 100, 200. All other values are rejected.
- DELIV_WAIT: count DELIV_CYC-1 cycles, then go to DELIVER.
- DELIVER (one cycle): beverage_out[idx]=1; credit -= PRICE[idx]; go to CHANGE_WAIT if the new credit < MIN_PRICE, else IDLE with credit kept.
- CHANGE_WAIT: count CHANGE_CYC-1 cycles, then go to CHANGE.
- CHANGE (one cycle): change_out=credit; change_valid=1; credit=0; go to IDLE. If credit is 0, change_valid is still pulsed with change_out=0.
- In any non-IDLE state: coin strobes are rejected (coin_reject pulse); selections and cancel are ignored.
- Arithmetic is unsigned CREDIT_W. Subtraction cannot underflow because affordability is checked first. Addition cannot overflow because of the MAX_CREDIT check.

## Timing
- Selection accepted at edge E0: beverage_out is high from edge E0+DELIV_CYC to edge E0+DELIV_CYC+1.
- Change path: CHANGE_WAIT is entered at edge E0+DELIV_CYC+1; change_valid is high from edge E0+DELIV_CYC+1+CHANGE_CYC for one cycle.
- Coin strobe at edge E: credit_out updates at edge E+1, or coin_reject pulses for cycle E+1.
- busy rises one edge after acceptance and falls on return to IDLE.
- Reset asserted mid-operation: all in-flight delivery and change is dropped, and the credit held at that moment is lost with no pulse. This behaviour is intentional.

## Configuration
- VEND_CANCEL_EN defined: in IDLE with credit > 0, cancel_in takes priority over select and coin. The controller goes to CHANGE_WAIT and refunds the full credit after CHANGE_CYC cycles. A coin strobed in the same cycle is rejected.
- VEND_CANCEL_EN undefined: cancel_in is ignored entirely; the port remains present and unconnected internally.

## Structure
- Package vend_pkg holds:
  - state enum vend_state_t;
  - price table PRICE[8] = {30, 50, 70, 100, 120, 150, 200, 250};
  - MIN_PRICE, the minimum over PRICE[0..N_PROD-1];
  - legal-coin constant list and function is_legal_coin().
- Sub-module vend_delay_cnt: loadable down-counter with a done flag, instanced once and shared by DELIV_WAIT and CHANGE_WAIT.

## Test plan
- Coins 10, 20, then select 0: beverage_out=0001 DELIV_CYC cycles later; credit 0; change_valid pulse with change_out=0.
- Coin 100, select 1 (price 50): beverage_out=0010; credit 50 ≥ 30 → IDLE, credit_out=50, no change pulse.
- Coin 5 and coin 30: coin_reject pulses both times; credit stays 0. Coins 200, 200, 100, then 10: credit 500, and the final 10 is rejected.
- Credit 20, select 0 (price 30): ignored, no busy. Coin 50 plus select 0 in the same cycle with credit 30: delivery starts and the coin is rejected.
- VEND_CANCEL_EN, credit 70, cancel_in: change_out=70 after CHANGE_CYC cycles, then credit 0. Without the macro: nothing happens.
- Reset asserted in DELIV_WAIT: all outputs 0 immediately, state IDLE, no beverage pulse afterwards.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types, price table and coin helpers for the vending-machine controller.
package vend_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDelivWait,
    StDeliver,
    StChangeWait,
    StChange
  } vend_state_t;

  localparam int unsigned N_PRICES = 8;
  localparam int unsigned PRICE [N_PRICES] = '{30, 50, 70, 100, 120, 150, 200, 250};

  localparam int unsigned N_LEGAL_COINS = 5;
  localparam int unsigned LEGAL_COINS [N_LEGAL_COINS] = '{10, 20, 50, 100, 200};

  // Cheapest product among the first n_prod entries; sets the change threshold.
  function automatic int unsigned min_price(input int unsigned n_prod);
    int unsigned m;
    m = PRICE[0];
    for (int unsigned i = 1; i < N_PRICES; i++) begin
      if (i < n_prod && PRICE[i] < m) m = PRICE[i];
    end
    return m;
  endfunction

  function automatic logic is_legal_coin(input int unsigned value);
    logic legal;
    legal = 1'b0;
    for (int unsigned i = 0; i < N_LEGAL_COINS; i++) begin
      if (value == LEGAL_COINS[i]) legal = 1'b1;
    end
    return legal;
  endfunction

endpackage

// File: rtl/vend_delay_cnt.sv
// Loadable down-counter; done is high while the count sits at zero.
module vend_delay_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q;

  // Load wins over counting; the count parks at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/vend_ctrl.sv
// Parametrised vending-machine controller: credit accumulation, product delivery
// and change return with cycle-counted delays.
// Optional feature: define VEND_CANCEL_EN to enable the cancel/refund request.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_W   = 16,
  parameter int unsigned N_PROD     = 4,
  parameter int unsigned DELIV_CYC  = 10,
  parameter int unsigned CHANGE_CYC = 20,
  parameter int unsigned MAX_CREDIT = 500,
  localparam int unsigned SEL_W     = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CREDIT_W-1:0] coin_in,
  input  logic                coin_valid,
  input  logic [SEL_W-1:0]    sel_in,
  input  logic                sel_valid,
  input  logic                cancel_in,
  output logic [N_PROD-1:0]   beverage_out,
  output logic [CREDIT_W-1:0] change_out,
  output logic                change_valid,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit_out,
  output logic                busy
);

  localparam int unsigned MIN_PRICE = min_price(N_PROD);
  localparam int unsigned MaxCyc    = (DELIV_CYC > CHANGE_CYC) ? DELIV_CYC : CHANGE_CYC;
  localparam int unsigned CntW      = $clog2(MaxCyc) + 1;

  vend_state_t         state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [SEL_W-1:0]    idx_q, idx_d;
  logic                coin_reject_q, coin_reject_d;

  logic                cnt_load;
  logic [CntW-1:0]     cnt_val;
  logic                cnt_done;

  logic [CREDIT_W-1:0] sel_price;
  logic [CREDIT_W-1:0] idx_price;
  logic [CREDIT_W-1:0] credit_left;
  logic [CREDIT_W:0]   coin_sum;
  logic                sel_ok;
  logic                coin_ok;
  logic                cancel_req;

  assign sel_price   = CREDIT_W'(PRICE[3'(sel_in)]);
  assign idx_price   = CREDIT_W'(PRICE[3'(idx_q)]);
  assign credit_left = credit_q - idx_price;
  // One extra bit so the ceiling check cannot be fooled by wrap-around.
  assign coin_sum    = {1'b0, credit_q} + {1'b0, coin_in};
  assign sel_ok      = sel_valid && (32'(sel_in) < N_PROD) && (credit_q >= sel_price);
  assign coin_ok     = is_legal_coin(32'(coin_in)) &&
                       (coin_sum <= (CREDIT_W + 1)'(MAX_CREDIT));

`ifdef VEND_CANCEL_EN
  assign cancel_req = cancel_in && (credit_q != '0);
`else
  logic unused_cancel;
  assign unused_cancel = cancel_in;
  assign cancel_req    = 1'b0;
`endif

  // One shared counter times both the delivery and the change delay.
  vend_delay_cnt #(
    .W (CntW)
  ) u_delay_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .done     (cnt_done)
  );

  // State, credit, selected index and the registered coin-reject pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      credit_q      <= '0;
      idx_q         <= '0;
      coin_reject_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      idx_q         <= idx_d;
      coin_reject_q <= coin_reject_d;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    idx_d         = idx_q;
    coin_reject_d = 1'b0;
    cnt_load      = 1'b0;
    cnt_val       = '0;
    beverage_out  = '0;
    change_out    = '0;
    change_valid  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cancel_req) begin
          state_d       = StChangeWait;
          cnt_load      = 1'b1;
          cnt_val       = CntW'(CHANGE_CYC - 1);
          coin_reject_d = coin_valid;
        end else if (sel_ok) begin
          idx_d         = sel_in;
          state_d       = StDelivWait;
          cnt_load      = 1'b1;
          cnt_val       = CntW'(DELIV_CYC - 1);
          coin_reject_d = coin_valid;
        end else if (coin_valid) begin
          if (coin_ok) credit_d = coin_sum[CREDIT_W-1:0];
          else         coin_reject_d = 1'b1;
        end
      end
      StDelivWait: begin
        coin_reject_d = coin_valid;
        if (cnt_done) state_d = StDeliver;
      end
      StDeliver: begin
        coin_reject_d = coin_valid;
        beverage_out  = N_PROD'(1) << idx_q;
        credit_d      = credit_left;
        if (credit_left < CREDIT_W'(MIN_PRICE)) begin
          state_d  = StChangeWait;
          cnt_load = 1'b1;
          cnt_val  = CntW'(CHANGE_CYC - 1);
        end else begin
          state_d = StIdle;
        end
      end
      StChangeWait: begin
        coin_reject_d = coin_valid;
        if (cnt_done) state_d = StChange;
      end
      StChange: begin
        coin_reject_d = coin_valid;
        change_out    = credit_q;
        change_valid  = 1'b1;
        credit_d      = '0;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign coin_reject = coin_reject_q;
  assign credit_out  = credit_q;
  assign busy        = (state_q != StIdle);

endmodule
